truth_table_sweeper: RTL and testbench

Synthesisable, parametrised sweep-and-check engine for combinational logic implementations (SDNF/MDNF/SKNF and similar). It walks every input vector of an `N_IN`-bit function and compares up to `N_CH` DUT outputs against a golden truth table. It records a per-vector pass map, per-channel mismatch counts and the first failing vector. It sits beside the DUTs in lab and FPGA test harnesses, replacing free-running simulation-only sweeps with a start/done-controlled checker that tolerates registered DUTs.

---
 rtl/truth_table_sweeper.sv | 176 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Sweep-and-check engine for combinational logic implementations. A sweep
// walks every N_IN-bit input vector in ascending order. Each vector is held on
// `args` for SETTLE+1 cycles, and the DUT outputs are sampled on the last edge
// of that window. Each of the N_CH channels is compared against the golden
// truth table TABLE.
//
// Parameters
//   N_IN    function input width (sweep length 2^N_IN)
//   N_CH    number of DUT channels checked in parallel
//   SETTLE  extra hold cycles per vector before sampling (0..255)
//   TABLE   golden truth table; vector 0 maps to the MSB
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a sweep (accepted in IDLE or DONE only)
//   stop_on_fail  latched at start acceptance; abort on first mismatch
//   args          current input vector driven to the DUTs
//   dut_res       DUT outputs, bit c = channel c
//   busy          sweep in progress
//   done          sweep finished or aborted, held until next accepted start
//   aborted       sweep ended early through stop_on_fail
//   pass_map      bit c*2^N_IN+k set when channel c matched at vector k
//   err_cnt       per-channel mismatch count, field c at [c*(N_IN+1) +: N_IN+1]
//   fail_seen     channel c mismatched at least once
//   first_fail    per-channel lowest failing vector, field c at [c*N_IN +: N_IN]
//
// Every output is driven straight from a register, so dut_res reaches no
// output through a combinational path.
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter int                   N_IN   = 5,
  parameter int                   N_CH   = 2,
  parameter int                   SETTLE = 0,
  parameter logic [(1<<N_IN)-1:0] TABLE  = 32'h2356BBFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop_on_fail,
  output logic [N_IN-1:0]               args,
  input  logic [N_CH-1:0]               dut_res,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [N_CH*(1<<N_IN)-1:0]     pass_map,
  output logic [N_CH*(N_IN+1)-1:0]      err_cnt,
  output logic [N_CH-1:0]               fail_seen,
  output logic [N_CH*N_IN-1:0]          first_fail
);

  localparam int NV = 1 << N_IN;   // vectors per sweep
  localparam int CW = N_IN + 1;    // counter width, large enough to hold NV

  // Reload value of the per-vector hold counter.
  localparam logic [7:0] SETTLE_V = 8'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state_r;
  logic [N_IN-1:0]               args_r;
  logic [7:0]                    settle_r;
  logic                          sof_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          aborted_r;
  logic [N_CH-1:0][NV-1:0]       pass_r;
  logic [N_CH-1:0][CW-1:0]       err_r;
  logic [N_CH-1:0]               fail_r;
  logic [N_CH-1:0][N_IN-1:0]     first_r;

  logic [N_IN-1:0]               exp_idx_s;
  logic                          exp_bit_s;
  logic [N_CH-1:0]               mism_s;
  logic                          abort_s;
  logic                          last_s;

  // Golden lookup and per-channel mismatch decode for the vector on args.
  always_comb begin
    // TABLE is MSB-first, so vector k sits at bit 2^N_IN-1-k, which is ~k.
    exp_idx_s = ~args_r;
    exp_bit_s = TABLE[exp_idx_s];
    mism_s    = dut_res ^ {N_CH{exp_bit_s}};
    abort_s   = sof_r & (|mism_s);
    last_s    = &args_r;
  end

  // Sweep controller: state, vector stepping, hold counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      args_r    <= {N_IN{1'b0}};
      settle_r  <= 8'd0;
      sof_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      pass_r    <= {(N_CH*NV){1'b0}};
      err_r     <= {(N_CH*CW){1'b0}};
      fail_r    <= {N_CH{1'b0}};
      first_r   <= {(N_CH*N_IN){1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r   <= RUN;
            args_r    <= {N_IN{1'b0}};
            settle_r  <= SETTLE_V;
            sof_r     <= stop_on_fail;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            pass_r    <= {(N_CH*NV){1'b0}};
            err_r     <= {(N_CH*CW){1'b0}};
            fail_r    <= {N_CH{1'b0}};
            first_r   <= {(N_CH*N_IN){1'b0}};
          end
        end

        RUN: begin
          // start is deliberately ignored here; the running sweep completes.
          if (settle_r != 8'd0) begin
            settle_r <= settle_r - 8'd1;
          end else begin
            for (int c = 0; c < N_CH; c++) begin
              if (mism_s[c]) begin
                err_r[c] <= err_r[c] + CW'(1);
                // The sweep ascends, so the first mismatch is the lowest one.
                if (!fail_r[c]) begin
                  fail_r[c]  <= 1'b1;
                  first_r[c] <= args_r;
                end
              end else begin
                pass_r[c][args_r] <= 1'b1;
              end
            end

            if (last_s || abort_s) begin
              // args stays on the final or failing vector; there is no wrap-around.
              state_r   <= DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              aborted_r <= abort_s;
            end else begin
              args_r   <= args_r + N_IN'(1);
              settle_r <= SETTLE_V;
            end
          end
        end

        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign args       = args_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign pass_map   = pass_r;
  assign err_cnt    = err_r;
  assign fail_seen  = fail_r;
  assign first_fail = first_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Drives a default-parameter sweeper with modelled DUTs (golden, stuck-at,
// single-vector inversion, random fault masks). It also drives a SETTLE=3
// sweeper whose DUT is a golden model with two register stages of latency.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop_on_fail = 1'b0;
  logic [4:0]  args;
  logic [1:0]  dut_res;
  logic        busy, done, aborted;
  logic [63:0] pass_map;
  logic [11:0] err_cnt;
  logic [1:0]  fail_seen;
  logic [9:0]  first_fail;

  logic        start3 = 1'b0;
  logic        sof3 = 1'b0;
  logic [4:0]  args3;
  logic [1:0]  res3;
  logic        busy3, done3, aborted3;
  logic [63:0] pass_map3;
  logic [11:0] err_cnt3;
  logic [1:0]  fail_seen3;
  logic [9:0]  first_fail3;

  int          mode = 0;
  logic [1:0]  rmask [32];
  logic        p1 = 1'b0, p2 = 1'b0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
    .args(args), .dut_res(dut_res), .busy(busy), .done(done), .aborted(aborted),
    .pass_map(pass_map), .err_cnt(err_cnt), .fail_seen(fail_seen),
    .first_fail(first_fail)
  );

  truth_table_sweeper #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stop_on_fail(sof3),
    .args(args3), .dut_res(res3), .busy(busy3), .done(done3), .aborted(aborted3),
    .pass_map(pass_map3), .err_cnt(err_cnt3), .fail_seen(fail_seen3),
    .first_fail(first_fail3)
  );

  always #5 clk = ~clk;

  // Golden function: vector k reads truth-table bit 31-k.
  function automatic logic gold(input logic [4:0] k);
    logic [31:0] t;
    t = 32'h2356BBFF;
    return t[5'd31 - k];
  endfunction

  // Modelled combinational DUTs for the default instance.
  always_comb begin
    dut_res = {gold(args), gold(args)};
    case (mode)
      1:       dut_res[1] = 1'b0;
      2:       if (args == 5'd5) dut_res[0] = ~gold(args);
      3:       dut_res = dut_res ^ rmask[args];
      default: ;
    endcase
  end

  // Golden DUT with two register stages for the SETTLE=3 instance.
  always @(posedge clk) begin
    p1 <= gold(args3);
    p2 <= p1;
  end
  assign res3 = {p2, p2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Start a sweep on the default instance and count edges until done.
  task automatic run_sweep(input string tag, input int md, input bit sof,
                           input int repulse, output int cycles);
    bit pulsed;
    pulsed = 1'b0;
    mode = md;
    @(negedge clk);
    start = 1'b1;
    stop_on_fail = sof;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop_on_fail = ~sof;  // only the value at acceptance may matter
    check({tag, "_acc_busy"}, 64'(busy), 64'd1);
    check({tag, "_acc_done"}, 64'(done), 64'd0);
    check({tag, "_acc_clear"}, {pass_map == 64'd0, err_cnt == 12'd0,
                                fail_seen == 2'd0, first_fail == 10'd0,
                                aborted, args}, 64'h3C0);
    cycles = -1;
    for (int n = 1; n <= 2000; n++) begin
      if (repulse >= 0 && !pulsed && args == 5'(repulse)) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic check_final(input string tag, input int cyc, input int exp_cyc,
                             input bit ab, input logic [4:0] a, input logic [11:0] ec,
                             input logic [9:0] ff, input logic [1:0] fs,
                             input logic [63:0] pm);
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_aborted"}, 64'(aborted), 64'(ab));
    check({tag, "_args"}, 64'(args), 64'(a));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(ec));
    check({tag, "_first_fail"}, 64'(first_fail), 64'(ff));
    check({tag, "_fail_seen"}, 64'(fail_seen), 64'(fs));
    check({tag, "_pass_map"}, pass_map, pm);
  endtask

  // Reference: walk vectors in order with the fault mask, stopping at the first fault if asked.
  task automatic ref_model(input bit sof, output int cyc, output bit ab, output logic [4:0] a,
                           output logic [11:0] ec, output logic [9:0] ff,
                           output logic [1:0] fs, output logic [63:0] pm);
    int errs [2];
    int firsts [2];
    int last;
    errs = '{0, 0};
    firsts = '{0, 0};
    pm = 64'd0;
    ab = 1'b0;
    last = 31;
    for (int k = 0; k < 32; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (rmask[k][c]) begin
          if (errs[c] == 0) firsts[c] = k;
          errs[c]++;
        end else begin
          pm[c*32 + k] = 1'b1;
        end
      end
      if (sof && rmask[k] != 2'b00) begin
        ab = 1'b1;
        last = k;
        break;
      end
    end
    cyc = last + 1;
    a = 5'(last);
    ec = {6'(errs[1]), 6'(errs[0])};
    ff = {5'(firsts[1]), 5'(firsts[0])};
    fs = {errs[1] != 0, errs[0] != 0};
  endtask

  typedef struct {
    int          md;
    bit          sof;
    int          cyc;
    bit          ab;
    logic [4:0]  a;
    logic [11:0] ec;
    logic [9:0]  ff;
    logic [1:0]  fs;
    logic [63:0] pm;
  } vec_t;

  initial begin
    vec_t        tv [3];
    int          cyc;
    int          r_cyc;
    bit          r_ab;
    bit          r_sof;
    logic [4:0]  r_a;
    logic [11:0] r_ec;
    logic [9:0]  r_ff;
    logic [1:0]  r_fs;
    logic [63:0] r_pm;
    bit          found;

    tv[0] = '{0, 1'b0, 32, 1'b0, 5'd31, 12'd0, 10'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[1] = '{1, 1'b0, 32, 1'b0, 5'd31, {6'd21, 6'd0}, {5'd2, 5'd0}, 2'b10,
              {32'h0022_953B, 32'hFFFF_FFFF}};
    tv[2] = '{2, 1'b1, 6, 1'b1, 5'd5, {6'd0, 6'd1}, {5'd0, 5'd5}, 2'b01,
              {32'h0000_003F, 32'h0000_001F}};
    for (int k = 0; k < 32; k++) rmask[k] = 2'b00;

    // Reset state.
    #2;
    check("rst_outputs", {args, busy, done, aborted, fail_seen, first_fail, err_cnt}, 64'd0);
    check("rst_pass_map", pass_map, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_start", {busy, done}, 64'd0);

    // Table-driven scenarios (tv[1] followed by tv[2] also covers start from DONE).
    for (int i = 0; i < 3; i++) begin
      run_sweep($sformatf("tv%0d", i), tv[i].md, tv[i].sof, -1, cyc);
      check_final($sformatf("tv%0d", i), cyc, tv[i].cyc, tv[i].ab, tv[i].a, tv[i].ec,
                  tv[i].ff, tv[i].fs, tv[i].pm);
    end

    // start re-pulsed at vector 7 is ignored.
    run_sweep("repulse", 0, 1'b0, 7, cyc);
    check_final("repulse", cyc, 32, 1'b0, 5'd31, 12'd0, 10'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized fault masks against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 32; k++) begin
        rmask[k] = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      end
      r_sof = 1'($urandom_range(0, 1));
      ref_model(r_sof, r_cyc, r_ab, r_a, r_ec, r_ff, r_fs, r_pm);
      run_sweep($sformatf("rnd%0d", r), 3, r_sof, -1, cyc);
      check_final($sformatf("rnd%0d", r), cyc, r_cyc, r_ab, r_a, r_ec, r_ff, r_fs, r_pm);
    end

    // Reset pulsed mid-sweep at vector 10.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (args == 5'd10) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("mid_reach_vec10", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {args, busy, done, aborted, fail_seen, first_fail, err_cnt}, 64'd0);
    check("mid_rst_pass_map", pass_map, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_stays_idle", {busy, done, args}, 64'd0);
    run_sweep("post_rst", 0, 1'b0, -1, cyc);
    check_final("post_rst", cyc, 32, 1'b0, 5'd31, 12'd0, 10'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);

    // SETTLE=3 with a two-cycle-latency DUT.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) check("s3_hold_vec0", 64'(args3), 64'd0);
      if (n == 4) check("s3_step_vec1", 64'(args3), 64'd1);
      if (done3) begin
        cyc = n;
        break;
      end
    end
    check("s3_cycles", 64'(cyc), 64'd128);
    check("s3_results", {busy3, aborted3, fail_seen3, first_fail3, err_cnt3, args3},
          {38'd0, 5'd31});
    check("s3_pass_map", pass_map3, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
